// File: rtl/oled_pkg.sv
// oled_pkg: state encoding and SSD1331 power-up command list shared by oled_seq.
package oled_pkg;
    typedef enum logic [2:0] {
        RST_LOW   = 3'd0,
        RST_WAIT  = 3'd1,
        CMD       = 3'd2,
        FETCH     = 3'd3,
        PIX_HI    = 3'd4,
        PIX_LO    = 3'd5,
        FRAME_GAP = 3'd6
    } oled_state_t;
    localparam int INIT_LEN = 25;
    localparam int IDX_W = $clog2(INIT_LEN);
    // off, remap, start line, offset, normal, mux, master cfg, precharge, clkdiv, contrast A/B/C, current, on
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
        8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4, 8'hA8, 8'h3F,
        8'hAD, 8'h8E, 8'hB1, 8'h31, 8'hB3, 8'hF0, 8'h81, 8'h91, 8'h82, 8'h50,
        8'h83, 8'h7D, 8'h87, 8'h06, 8'hAF
    };
endpackage

// File: rtl/oled_seq_timer.sv
// oled_seq_timer: loadable down-counter; done is high while the count sits at zero.
module oled_seq_timer #(
    parameter logic [15:0] RST_VAL = 16'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        done
);
    logic [15:0] cnt_q, cnt_d;
    assign done = cnt_q == 16'd0;
    always_comb cnt_d = load ? load_val : (done ? cnt_q : cnt_q - 16'd1);
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= RST_VAL;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/oled_seq.sv
// oled_seq: SSD1331 panel sequencer (reset, command list, RGB565 frame streaming).
// OLED_SEQ_FRAME_TICK_EN adds frame_tick, which gates the start of every frame.
module oled_seq
    import oled_pkg::*;
#(
    parameter logic [15:0] RESET_CYCLES = 16'd2000,
    parameter logic [15:0] WAIT_CYCLES  = 16'd2000,
    parameter int          WIDTH        = 96,
    parameter int          HEIGHT       = 64
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef OLED_SEQ_FRAME_TICK_EN
    input  logic        frame_tick,
`endif
    output logic [7:0]  tx_data,
    output logic        tx_dc,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        oled_res_n,
    output logic        oled_cs_n,
    output logic [6:0]  px_x,
    output logic [5:0]  px_y,
    input  logic [15:0] px_color,
    output logic        init_done,
    output logic        frame_done
);
    oled_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      color_q, color_d;
    logic [6:0]       px_x_q, px_x_d;
    logic [5:0]       px_y_q, px_y_d;
    logic             init_done_q, init_done_d, frame_done_q, frame_done_d;
    logic             tmr_done, xfer, last_cmd, last_x, last_px, go;

`ifdef OLED_SEQ_FRAME_TICK_EN
    localparam oled_state_t FIRST_FRAME = FRAME_GAP;
    assign go = frame_tick;
`else
    localparam oled_state_t FIRST_FRAME = FETCH;
    assign go = 1'b1;
`endif

    oled_seq_timer #(.RST_VAL(RESET_CYCLES - 16'd1)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_q == RST_LOW && tmr_done),
        .load_val (WAIT_CYCLES - 16'd1),
        .done     (tmr_done)
    );

    assign xfer       = tx_valid && tx_ready;
    assign last_cmd   = idx_q == IDX_W'(INIT_LEN - 1);
    assign last_x     = px_x_q == 7'(WIDTH - 1);
    assign last_px    = last_x && px_y_q == 6'(HEIGHT - 1);
    assign oled_res_n = state_q != RST_LOW;
    assign oled_cs_n  = state_q == RST_LOW || state_q == RST_WAIT;
    assign tx_valid   = state_q == CMD || state_q == PIX_HI || state_q == PIX_LO;
    assign tx_dc      = state_q == PIX_HI || state_q == PIX_LO;
    assign tx_data    = state_q == CMD    ? INIT_ROM[idx_q] :
                        state_q == PIX_HI ? color_q[15:8]   :
                        state_q == PIX_LO ? color_q[7:0]    : 8'h00;
    assign px_x       = px_x_q;
    assign px_y       = px_y_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        color_d      = color_q;
        px_x_d       = px_x_q;
        px_y_d       = px_y_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        case (state_q)
            RST_LOW:   state_d = tmr_done ? RST_WAIT : RST_LOW;
            RST_WAIT:  state_d = tmr_done ? CMD : RST_WAIT;
            CMD: if (xfer) begin
                idx_d       = last_cmd ? idx_q : idx_q + 1'b1;
                state_d     = last_cmd ? FIRST_FRAME : CMD;
                init_done_d = init_done_q || last_cmd;
            end
            FETCH: begin
                color_d = px_color;
                state_d = PIX_HI;
            end
            PIX_HI:    state_d = xfer ? PIX_LO : PIX_HI;
            PIX_LO: if (xfer) begin
                px_x_d       = last_x ? 7'd0 : px_x_q + 7'd1;
                px_y_d       = last_px ? 6'd0 : (last_x ? px_y_q + 6'd1 : px_y_q);
                frame_done_d = last_px;
                state_d      = last_px ? FRAME_GAP : FETCH;
            end
            FRAME_GAP: state_d = go ? FETCH : FRAME_GAP;
            default:   state_d = RST_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RST_LOW;
            idx_q        <= '0;
            color_q      <= 16'h0000;
            px_x_q       <= 7'd0;
            px_y_q       <= 6'd0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            color_q      <= color_d;
            px_x_q       <= px_x_d;
            px_y_q       <= px_y_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule
